reg_sequencer: RTL and testbench
================================

REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 The block SHALL have no parameters; all data paths SHALL be 8 bits and all register addresses SHALL be 2 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the instruction-handshake input ports: INS_VALID (1 bit, instruction offered), OP (3 bits, opcode), RD (2 bits, destination register), RS1 (2 bits, source A), RS2 (2 bits, source B) and IMM (8 bits, immediate for LOADI).
REQ-005 The block SHALL have output INS_READY, 1 bit: the instruction is accepted on a clk edge where INS_VALID=1 and INS_READY=1.
REQ-006 The block SHALL have the register-file-side output ports: DIR_A (2 bits), DIR_B (2 bits), DIR_WR (2 bits), DI (8 bits, write data) and EN (1 bit, 1=write, 0=read).
REQ-007 The block SHALL have the register-file-side input ports DOA and DOB, 8 bits each: operands registered by the register file on the edge ending a cycle with EN=0.
REQ-008 The block SHALL have the status output ports: RESULT (8 bits, last written value), FLAG_Z (1 bit), FLAG_C (1 bit), BUSY (1 bit, state != IDLE) and DONE (1 bit, one-cycle completion pulse).

Function
REQ-009 The block SHALL implement an FSM with states IDLE, READ, EXEC and WRITE; INS_READY SHALL be 1 only in IDLE.
REQ-010 On acceptance, OP/RD/RS1/RS2/IMM SHALL be latched; inputs in other states SHALL be ignored.
REQ-011 The accepting transition SHALL be: for OP in {ADD=000, SUB=001, AND=010, OR=011, XOR=100}, IDLE->READ; for LOADI=101, IDLE->WRITE; for NOP=110 or 111 (reserved), IDLE stays in IDLE with DONE=1 on the next cycle and no write.
REQ-012 In READ, the block SHALL drive DIR_A=RS1, DIR_B=RS2 and EN=0 for exactly one cycle, then go to EXEC.
REQ-013 In EXEC, the block SHALL sample DOA/DOB, compute the result into an internal result register, keep EN=0, then go to WRITE.
REQ-014 The arithmetic SHALL be: ADD = DOA+DOB mod 256 with C = carry-out; SUB = DOA-DOB mod 256 with C = 1 when DOA<DOB (borrow); AND/OR/XOR bitwise with C=0; Z = (result==0).
REQ-015 FLAG_Z and FLAG_C SHALL update only at the end of EXEC; LOADI and NOP SHALL leave both flags unchanged.
REQ-016 In WRITE, the block SHALL drive EN=1, DIR_WR=latched RD and DI=result (IMM for LOADI) for exactly one cycle; RESULT SHALL update at the end of WRITE; the next state SHALL be IDLE.
REQ-017 DONE SHALL be 1 for exactly the one cycle following WRITE (or following NOP acceptance), and 0 otherwise.
REQ-018 EN SHALL be 1 only in WRITE; outside WRITE, DIR_WR and DI SHALL hold their last values.
REQ-019 Outside READ, DIR_A and DIR_B SHALL hold their last values.
REQ-020 The latency from acceptance to DONE SHALL be 4 cycles for ALU ops, 2 for LOADI and 1 for NOP; back-to-back ALU ops SHALL accept every 4 cycles.
REQ-021 Because a write completes before the next READ, RD==RS1 or RD==RS2 in consecutive instructions SHALL read the newly written value with no stall.
REQ-022 RD=RS1=RS2 (e.g. x1=x1+x1) SHALL be legal and produce the correct result.

Reset
REQ-023 While rst_n=0, the block SHALL set state=IDLE, EN=0, DIR_A=DIR_B=DIR_WR=0, DI=0, RESULT=0, FLAG_Z=0, FLAG_C=0, DONE=0 and BUSY=0, taking effect immediately without a clock.
REQ-024 A reset asserted in any state SHALL abort the instruction: no write SHALL occur, and EN SHALL drop to 0 within the reset assertion even mid-WRITE.
REQ-025 After rst_n rises, the first instruction SHALL be accepted on the first clk edge with INS_VALID=1.

Verification
REQ-026 Bench scenario: LOADI RD=2 IMM=0x5A -> EN=1, DIR_WR=2, DI=0x5A one cycle after acceptance; DONE next cycle; RESULT=0x5A; flags unchanged.
REQ-027 Bench scenario: x0=0xF0, x1=0x20, ADD RD=3 RS1=0 RS2=1 -> READ drives DIR_A=0/DIR_B=1; WRITE DI=0x10; FLAG_C=1, FLAG_Z=0; DONE 4 cycles after acceptance.
REQ-028 Bench scenario: x2=0x33, SUB RD=2 RS1=2 RS2=2 -> DI=0x00, FLAG_Z=1, FLAG_C=0; then x2 reads 0x00.
REQ-029 Bench scenario: LOADI x1=0x07, then immediately ADD RD=0 RS1=1 RS2=1 -> DI=0x0E (no stale-read hazard); INS_READY=0 in READ/EXEC/WRITE.
REQ-030 Bench scenario: assert rst_n=0 during WRITE of ADD -> EN falls immediately, target register unchanged, all outputs at REQ-023 values; after release, NOP accepted with DONE one cycle later and no EN pulse.
REQ-031 Bench scenario: OP=111 with INS_VALID held for 3 cycles -> three accepts, three DONE pulses, EN stays 0, flags unchanged.

Source files
------------

// File: rtl/reg_sequencer.sv
// Instruction sequencer for a 4-entry, 8-bit register file with a registered read port.
// Each accepted instruction walks IDLE -> READ -> EXEC -> WRITE and then pulses DONE.
module reg_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INS_VALID,
    input  logic [2:0] OP,
    input  logic [1:0] RD,
    input  logic [1:0] RS1,
    input  logic [1:0] RS2,
    input  logic [7:0] IMM,
    output logic       INS_READY,
    output logic [1:0] DIR_A,
    output logic [1:0] DIR_B,
    output logic [1:0] DIR_WR,
    output logic [7:0] DI,
    output logic       EN,
    input  logic [7:0] DOA,
    input  logic [7:0] DOB,
    output logic [7:0] RESULT,
    output logic       FLAG_Z,
    output logic       FLAG_C,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_LOADI = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t     r_state, w_next;
    logic [2:0] r_op;
    logic [1:0] r_rd;
    logic [1:0] r_dir_a, r_dir_b, r_dir_wr;
    logic [7:0] r_di, r_result;
    logic       r_z, r_c, r_done;

    logic       w_accept, w_is_alu;
    logic [8:0] w_sum, w_diff;
    logic [7:0] w_alu;
    logic       w_carry;

    assign w_accept = (r_state == S_IDLE) && INS_VALID;
    assign w_is_alu = (OP <= OP_XOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_alu)             w_next = S_READ;
                    else if (OP == OP_LOADI)  w_next = S_WRITE;
                    else                      w_next = S_IDLE;
                end
            end
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // 9-bit arithmetic: bit 8 is carry-out for ADD and borrow for SUB
    assign w_sum  = {1'b0, DOA} + {1'b0, DOB};
    assign w_diff = {1'b0, DOA} - {1'b0, DOB};

    always_comb begin
        w_alu   = 8'h00;
        w_carry = 1'b0;
        case (r_op)
            OP_ADD: begin w_alu = w_sum[7:0];  w_carry = w_sum[8];  end
            OP_SUB: begin w_alu = w_diff[7:0]; w_carry = w_diff[8]; end
            OP_AND: w_alu = DOA & DOB;
            OP_OR:  w_alu = DOA | DOB;
            OP_XOR: w_alu = DOA ^ DOB;
            default: begin w_alu = 8'h00; w_carry = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 3'd0;
            r_rd     <= 2'd0;
            r_dir_a  <= 2'd0;
            r_dir_b  <= 2'd0;
            r_dir_wr <= 2'd0;
            r_di     <= 8'h00;
            r_result <= 8'h00;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= OP;
                        r_rd <= RD;
                        // Read addresses go out during READ; LOADI skips straight to WRITE
                        if (w_is_alu) begin
                            r_dir_a <= RS1;
                            r_dir_b <= RS2;
                        end else if (OP == OP_LOADI) begin
                            r_dir_wr <= RD;
                            r_di     <= IMM;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_di     <= w_alu;
                    r_dir_wr <= r_rd;
                    r_z      <= (w_alu == 8'h00);
                    r_c      <= w_carry;
                end
                S_WRITE: begin
                    r_result <= r_di;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // EN decodes from the async-reset state so a reset kills a write at once
    assign EN        = (r_state == S_WRITE);
    assign INS_READY = (r_state == S_IDLE);
    assign BUSY      = (r_state != S_IDLE);
    assign DIR_A     = r_dir_a;
    assign DIR_B     = r_dir_b;
    assign DIR_WR    = r_dir_wr;
    assign DI        = r_di;
    assign RESULT    = r_result;
    assign FLAG_Z    = r_z;
    assign FLAG_C    = r_c;
    assign DONE      = r_done;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer with a behavioural 4x8 register file behind it.
module tb_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       INS_VALID;
    logic [2:0] OP;
    logic [1:0] RD, RS1, RS2;
    logic [7:0] IMM;
    logic       INS_READY;
    logic [1:0] DIR_A, DIR_B, DIR_WR;
    logic [7:0] DI;
    logic       EN;
    logic [7:0] DOA, DOB;
    logic [7:0] RESULT;
    logic       FLAG_Z, FLAG_C, BUSY, DONE;

    logic [7:0] rf [4];
    logic       exp_z, exp_c;
    int         total  = 0;
    int         passed = 0;

    reg_sequencer dut (
        .clk(clk), .rst_n(rst_n), .INS_VALID(INS_VALID), .OP(OP), .RD(RD),
        .RS1(RS1), .RS2(RS2), .IMM(IMM), .INS_READY(INS_READY),
        .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WR(DIR_WR), .DI(DI), .EN(EN),
        .DOA(DOA), .DOB(DOB), .RESULT(RESULT), .FLAG_Z(FLAG_Z),
        .FLAG_C(FLAG_C), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    // Register file: write when EN=1, otherwise register both read ports
    always @(posedge clk) begin
        if (EN) rf[DIR_WR] <= DI;
        else begin
            DOA <= rf[DIR_A];
            DOB <= rf[DIR_B];
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [7:0] imm);
        INS_VALID = 1'b1; OP = op; RD = rd; RS1 = rs1; RS2 = rs2; IMM = imm;
    endtask

    task automatic loadi(input logic [1:0] rd, input logic [7:0] v);
        drive(3'b101, rd, 2'd0, 2'd0, v);
        tick();
        INS_VALID = 1'b0;
        chk("li_en", EN, 1);
        chk("li_dirwr", DIR_WR, rd);
        chk("li_di", DI, v);
        chk("li_ready", INS_READY, 0);
        chk("li_done0", DONE, 0);
        tick();
        chk("li_done", DONE, 1);
        chk("li_en0", EN, 0);
        chk("li_result", RESULT, v);
        chk("li_z", FLAG_Z, exp_z);
        chk("li_c", FLAG_C, exp_c);
        chk("li_rf", rf[rd], v);
    endtask

    // Runs one ALU op; conflicting inputs are offered while busy and must be ignored
    task automatic alu(input logic [2:0] op, input logic [1:0] rd, rs1, rs2,
                       input logic [7:0] edi, input logic ez, input logic ec);
        drive(op, rd, rs1, rs2, 8'hEE);
        tick();
        drive(3'b101, ~rd, ~rs1, ~rs2, 8'hEE);
        chk("rd_dira", DIR_A, rs1);
        chk("rd_dirb", DIR_B, rs2);
        chk("rd_en", EN, 0);
        chk("rd_ready", INS_READY, 0);
        chk("rd_busy", BUSY, 1);
        tick();
        chk("ex_en", EN, 0);
        chk("ex_ready", INS_READY, 0);
        chk("ex_dira", DIR_A, rs1);
        tick();
        chk("wr_en", EN, 1);
        chk("wr_dirwr", DIR_WR, rd);
        chk("wr_di", DI, edi);
        chk("wr_z", FLAG_Z, ez);
        chk("wr_c", FLAG_C, ec);
        chk("wr_ready", INS_READY, 0);
        chk("wr_done", DONE, 0);
        tick();
        INS_VALID = 1'b0;
        chk("alu_done", DONE, 1);
        chk("alu_en0", EN, 0);
        chk("alu_busy0", BUSY, 0);
        chk("alu_result", RESULT, edi);
        chk("alu_rf", rf[rd], edi);
        exp_z = ez;
        exp_c = ec;
    endtask

    task automatic chk_reset_vals();
        chk("rst_en", EN, 0);
        chk("rst_done", DONE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", INS_READY, 1);
        chk("rst_dira", DIR_A, 0);
        chk("rst_dirb", DIR_B, 0);
        chk("rst_dirwr", DIR_WR, 0);
        chk("rst_di", DI, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_z", FLAG_Z, 0);
        chk("rst_c", FLAG_C, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        exp_z = 1'b0; exp_c = 1'b0;
        rst_n = 1'b0;
        drive(3'b110, 2'd0, 2'd0, 2'd0, 8'h00);
        INS_VALID = 1'b0;
        #2;
        chk_reset_vals();
        tick(); tick();
        rst_n = 1'b1;

        // LOADI x2=0x5A
        loadi(2'd2, 8'h5A);
        tick();
        chk("done_1cyc", DONE, 0);

        // x0=F0, x1=20, ADD x3 = x0+x1 -> 0x10 with carry
        loadi(2'd0, 8'hF0);
        loadi(2'd1, 8'h20);
        alu(3'b000, 2'd3, 2'd0, 2'd1, 8'h10, 1'b0, 1'b1);

        // x2=33, SUB x2 = x2-x2 -> 0, Z=1; then x2 reads back as 0
        loadi(2'd2, 8'h33);
        alu(3'b001, 2'd2, 2'd2, 2'd2, 8'h00, 1'b1, 1'b0);
        alu(3'b000, 2'd3, 2'd2, 2'd0, 8'hF0, 1'b0, 1'b0);

        // SUB with borrow, then logic ops
        alu(3'b001, 2'd3, 2'd1, 2'd0, 8'h30, 1'b0, 1'b1);
        alu(3'b010, 2'd1, 2'd0, 2'd1, 8'h20, 1'b0, 1'b0);
        alu(3'b011, 2'd2, 2'd1, 2'd0, 8'hF0, 1'b0, 1'b0);
        alu(3'b100, 2'd3, 2'd3, 2'd3, 8'h00, 1'b1, 1'b0);

        // LOADI x1=07 then ADD x0 = x1+x1 immediately
        loadi(2'd1, 8'h07);
        alu(3'b000, 2'd0, 2'd1, 2'd1, 8'h0E, 1'b0, 1'b0);

        // Reset during WRITE of ADD x3 = x1+x0 (0x15): write must be aborted
        drive(3'b000, 2'd3, 2'd1, 2'd0, 8'h00);
        tick();
        INS_VALID = 1'b0;
        tick(); tick();
        chk("ab_en", EN, 1);
        chk("ab_di", DI, 8'h15);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_z = 1'b0; exp_c = 1'b0;
        tick();
        chk("ab_rf", rf[3], 8'h00);
        chk("ab_en_hold", EN, 0);
        rst_n = 1'b1;

        // NOP right after reset release
        drive(3'b110, 2'd1, 2'd0, 2'd0, 8'h00);
        tick();
        INS_VALID = 1'b0;
        chk("nop_done", DONE, 1);
        chk("nop_en", EN, 0);
        chk("nop_busy", BUSY, 0);
        tick();
        chk("nop_done0", DONE, 0);

        // x2 = x2+x2 with RD=RS1=RS2: F0+F0 -> E0 carry
        alu(3'b000, 2'd2, 2'd2, 2'd2, 8'hE0, 1'b0, 1'b1);

        // Reserved op held valid for three cycles
        drive(3'b111, 2'd2, 2'd2, 2'd2, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r111_done", DONE, 1);
            chk("r111_en", EN, 0);
            chk("r111_ready", INS_READY, 1);
            chk("r111_z", FLAG_Z, exp_z);
            chk("r111_c", FLAG_C, exp_c);
        end
        INS_VALID = 1'b0;
        tick();
        chk("r111_done0", DONE, 0);
        chk("r111_rf", rf[2], 8'hE0);
        chk("r111_result", RESULT, 8'hE0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
